or_out_responder: RTL

OR_OUT_RESPONDER -- requirements
Module: or_out_responder

---
 rtl/or_out_pkg.sv | 13 +
 rtl/or_out_if.sv | 27 ++
 rtl/or_out_fifo.sv | 65 ++++++
 rtl/or_out_responder.sv | 69 ++++++
 4 files changed

// File: rtl/or_out_pkg.sv
// Shared defaults and types for the OR result responder.
package or_out_pkg;

    localparam int unsigned OR_IN_WIDTH_DEFAULT = 8;
    localparam int unsigned DEPTH_DEFAULT       = 4;
    localparam int unsigned TXN_CNT_W           = 16;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } rdy_state_e;

endpackage

// File: rtl/or_out_if.sv
// Operand/result handshake bundle between a producer/consumer and the responder.
interface or_out_if
    import or_out_pkg::*;
#(
    parameter int unsigned OR_in_WIDTH = OR_IN_WIDTH_DEFAULT
) ();

    logic [OR_in_WIDTH-1:0] a;
    logic [OR_in_WIDTH-1:0] b;
    logic                   in_valid;
    logic                   in_ready;
    logic [OR_in_WIDTH-1:0] y;
    logic                   y_zero;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, y, y_zero, out_valid
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, y, y_zero, out_valid
    );

endinterface

// File: rtl/or_out_fifo.sv
// Result buffer: power-of-two circular storage with occupancy count.
module or_out_fifo
    import or_out_pkg::*;
#(
    parameter int unsigned OR_in_WIDTH = OR_IN_WIDTH_DEFAULT,
    parameter int unsigned DEPTH       = DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [OR_in_WIDTH-1:0]       wr_data,
    output logic [OR_in_WIDTH-1:0]       rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [OR_in_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q,  count_d;
    logic                   do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/or_out_responder.sv
// Buffers a|b results from the operand bus and hands them downstream in order.
module or_out_responder
    import or_out_pkg::*;
#(
    parameter int unsigned OR_in_WIDTH = OR_IN_WIDTH_DEFAULT,
    parameter int unsigned DEPTH       = DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    or_out_if.slave                     bus,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic [TXN_CNT_W-1:0]        txn_cnt
);

    rdy_state_e             state_q, state_d;
    logic [TXN_CNT_W-1:0]   txn_cnt_q, txn_cnt_d;
    logic                   push, pop, full, empty;
    logic [OR_in_WIDTH-1:0] head;

    // Ready stays low through the reset edge and rises on the first running edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_RUN) && !full;
    assign bus.out_valid = !empty;
    assign bus.y         = head;
    assign bus.y_zero    = (head == '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        txn_cnt_d = txn_cnt_q;
        if (pop) txn_cnt_d = txn_cnt_q + TXN_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_INIT;
            txn_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign txn_cnt = txn_cnt_q;

    or_out_fifo #(
        .OR_in_WIDTH (OR_in_WIDTH),
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.a | bus.b),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

endmodule
